// File: rtl/vga_text_writer.sv
// Text-mode character writer: takes ASCII over valid/ready, tracks a cursor,
// handles control codes and sweeps blank fills into the video character RAM.
module vga_text_writer #(
    parameter int          COLS  = 70,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t      state, state_n;
    logic [4:0]  sweep_row, sweep_row_n;
    logic [6:0]  sweep_col, sweep_col_n;
    logic [4:0]  row_n;
    logic [6:0]  col_n;
    logic        wr_en_n;
    logic [11:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic        ready_n;
    logic        advance;
    logic        take;
    logic        printable;

    assign take      = char_valid & char_ready;
    assign printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign busy      = ~char_ready;

    // Next-state and next-output decode; every register is loaded from here.
    always_comb begin
        state_n     = state;
        sweep_row_n = sweep_row;
        sweep_col_n = sweep_col;
        row_n       = cursor_row;
        col_n       = cursor_col;
        wr_en_n     = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        ready_n     = char_ready;
        advance     = 1'b0;

        case (state)
            CLR_ALL: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {sweep_row, sweep_col};
                wr_data_n = BLANK;
                ready_n   = 1'b0;
                if (sweep_col == LAST_COL) begin
                    sweep_col_n = 7'd0;
                    if (sweep_row == LAST_ROW) begin
                        sweep_row_n = 5'd0;
                        state_n     = IDLE;
                        ready_n     = 1'b1;
                        row_n       = 5'd0;
                        col_n       = 7'd0;
                    end else begin
                        sweep_row_n = sweep_row + 5'd1;
                    end
                end else begin
                    sweep_col_n = sweep_col + 7'd1;
                end
            end

            IDLE: begin
                ready_n = 1'b1;
                if (take) begin
                    if (printable) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = {cursor_row, cursor_col};
                        wr_data_n = char_in;
                        if (cursor_col == LAST_COL)
                            advance = 1'b1;
                        else
                            col_n = cursor_col + 7'd1;
                    end else begin
                        case (char_in)
                            8'h0A: advance = 1'b1;
                            8'h0D: col_n = 7'd0;
                            8'h08: begin
                                if (cursor_col != 7'd0) begin
                                    col_n     = cursor_col - 7'd1;
                                    wr_en_n   = 1'b1;
                                    wr_addr_n = {cursor_row, cursor_col - 7'd1};
                                    wr_data_n = BLANK;
                                end
                            end
                            8'h0C: begin
                                row_n       = 5'd0;
                                col_n       = 7'd0;
                                sweep_row_n = 5'd0;
                                sweep_col_n = 7'd0;
                                state_n     = CLR_ALL;
                                ready_n     = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            CLR_ROW: begin
                wr_en_n   = 1'b1;
                wr_addr_n = {cursor_row, sweep_col};
                wr_data_n = BLANK;
                ready_n   = 1'b0;
                if (sweep_col == LAST_COL) begin
                    sweep_col_n = 7'd0;
                    state_n     = IDLE;
                    ready_n     = 1'b1;
                end else begin
                    sweep_col_n = sweep_col + 7'd1;
                end
            end

            default: state_n = CLR_ALL;
        endcase

        // No scrolling: the row wraps and the freshly entered row is blanked.
        if (advance) begin
            col_n       = 7'd0;
            row_n       = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
            sweep_col_n = 7'd0;
            state_n     = CLR_ROW;
            ready_n     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLR_ALL;
            sweep_row  <= 5'd0;
            sweep_col  <= 7'd0;
            cursor_row <= 5'd0;
            cursor_col <= 7'd0;
            wr_en      <= 1'b0;
            wr_addr    <= 12'd0;
            wr_data    <= BLANK;
            char_ready <= 1'b0;
        end else begin
            state      <= state_n;
            sweep_row  <= sweep_row_n;
            sweep_col  <= sweep_col_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            char_ready <= ready_n;
        end
    end

endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer: reset sweep, printable writes, line wrap,
// control codes, form feed and reset during a row clear.
module tb_vga_text_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    int total = 0;
    int bad   = 0;

    vga_text_writer dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One-cycle transfer; returns on the negedge where its result is visible.
    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cyc, output int nwr);
        cyc = 0;
        nwr = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (wr_en) nwr++;
        end while (!char_ready && cyc < 5000);
    endtask

    task automatic test_reset;
        int r, c;
        logic [11:0] exp_addr;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({wr_en, wr_addr, wr_data, char_ready, busy, cursor_row, cursor_col} !==
            {1'b0, 12'h000, 8'h20, 1'b0, 1'b1, 5'd0, 7'd0}) begin
            bad++;
            $display("FAIL reset_values got en=%b a=%h d=%h rdy=%b busy=%b r=%0d c=%0d",
                     wr_en, wr_addr, wr_data, char_ready, busy, cursor_row, cursor_col);
        end
        reset = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            r = i / 70;
            c = i % 70;
            exp_addr = 12'(r * 128 + c);
            total++;
            if (!wr_en || wr_addr !== exp_addr || wr_data !== 8'h20 || char_ready !== (i == 2099)) begin
                bad++;
                $display("FAIL clr_all[%0d] got en=%b a=%h d=%h rdy=%b want a=%h", i, wr_en,
                         wr_addr, wr_data, char_ready, exp_addr);
            end
        end
        total++;
        if (wr_addr !== 12'hEC5) begin
            bad++;
            $display("FAIL clr_all_last got=%h want=ec5", wr_addr);
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || char_ready !== 1'b1 || busy !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL clr_all_done got en=%b rdy=%b busy=%b r=%0d c=%0d", wr_en, char_ready,
                     busy, cursor_row, cursor_col);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        char_in    = 8'h41;
        char_valid = 1'b1;
        @(negedge clk);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 12'h000 || wr_data !== 8'h41 || cursor_col !== 7'd1) begin
            bad++;
            $display("FAIL b2b_A got en=%b a=%h d=%h c=%0d want 1 000 41 1", wr_en, wr_addr, wr_data, cursor_col);
        end
        char_in = 8'h42;
        @(negedge clk);
        char_valid = 1'b0;
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 12'h001 || wr_data !== 8'h42 || cursor_col !== 7'd2) begin
            bad++;
            $display("FAIL b2b_B got en=%b a=%h d=%h c=%0d want 1 001 42 2", wr_en, wr_addr, wr_data, cursor_col);
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || wr_addr !== 12'h001 || wr_data !== 8'h42) begin
            bad++;
            $display("FAIL b2b_hold got en=%b a=%h d=%h want 0 001 42", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_line_wrap;
        int cyc, nwr;
        send_char(8'h0D);
        for (int i = 0; i < 3; i++) begin
            send_char(8'h0A);
            wait_ready(cyc, nwr);
            total++;
            if (nwr != 70 || cyc >= 5000) begin
                bad++;
                $display("FAIL lf_clear[%0d] got writes=%0d cycles=%0d want 70", i, nwr, cyc);
            end
        end
        for (int i = 0; i < 69; i++) send_char(8'h61);
        total++;
        if (cursor_row !== 5'd3 || cursor_col !== 7'd69) begin
            bad++;
            $display("FAIL wrap_pos got r=%0d c=%0d want 3 69", cursor_row, cursor_col);
        end
        send_char(8'h5A);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 12'h1C5 || wr_data !== 8'h5A || char_ready !== 1'b0) begin
            bad++;
            $display("FAIL wrap_Z got en=%b a=%h d=%h rdy=%b want 1 1c5 5a 0", wr_en, wr_addr, wr_data, char_ready);
        end
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            total++;
            if (!wr_en || wr_addr !== 12'(12'h200 + k) || wr_data !== 8'h20 || char_ready !== (k == 69)) begin
                bad++;
                $display("FAIL wrap_clr[%0d] got en=%b a=%h d=%h rdy=%b", k, wr_en, wr_addr, wr_data, char_ready);
            end
        end
        total++;
        if (cursor_row !== 5'd4 || cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL wrap_cursor got r=%0d c=%0d want 4 0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_row_wrap_and_cr;
        int cyc, nwr;
        for (int i = 0; i < 25; i++) begin
            send_char(8'h0A);
            wait_ready(cyc, nwr);
        end
        total++;
        if (cursor_row !== 5'd29 || cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL at_last_row got r=%0d c=%0d want 29 0", cursor_row, cursor_col);
        end
        send_char(8'h0A);
        total++;
        if (wr_en !== 1'b0 || char_ready !== 1'b0 || cursor_row !== 5'd0) begin
            bad++;
            $display("FAIL lf_wrap got en=%b rdy=%b r=%0d want 0 0 0", wr_en, char_ready, cursor_row);
        end
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            total++;
            if (!wr_en || wr_addr !== 12'(k) || wr_data !== 8'h20 || char_ready !== (k == 69)) begin
                bad++;
                $display("FAIL row0_clr[%0d] got en=%b a=%h d=%h rdy=%b", k, wr_en, wr_addr, wr_data, char_ready);
            end
        end
        for (int i = 0; i < 5; i++) send_char(8'h78);
        total++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd5) begin
            bad++;
            $display("FAIL pre_cr got r=%0d c=%0d want 0 5", cursor_row, cursor_col);
        end
        send_char(8'h0D);
        total++;
        if (wr_en !== 1'b0 || cursor_col !== 7'd0 || char_ready !== 1'b1) begin
            bad++;
            $display("FAIL cr got en=%b c=%0d rdy=%b want 0 0 1", wr_en, cursor_col, char_ready);
        end
    endtask

    task automatic test_backspace;
        int cyc, nwr;
        send_char(8'h08);
        total++;
        if (wr_en !== 1'b0 || cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL bs_col0 got en=%b c=%0d want 0 0", wr_en, cursor_col);
        end
        for (int i = 0; i < 2; i++) begin
            send_char(8'h0A);
            wait_ready(cyc, nwr);
        end
        for (int i = 0; i < 7; i++) send_char(8'h71);
        send_char(8'h08);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 12'h106 || wr_data !== 8'h20 || cursor_row !== 5'd2 || cursor_col !== 7'd6) begin
            bad++;
            $display("FAIL bs_col7 got en=%b a=%h d=%h r=%0d c=%0d want 1 106 20 2 6", wr_en, wr_addr,
                     wr_data, cursor_row, cursor_col);
        end
        send_char(8'h07);
        total++;
        if (wr_en !== 1'b0 || cursor_col !== 7'd6 || char_ready !== 1'b1) begin
            bad++;
            $display("FAIL bell got en=%b c=%0d rdy=%b want 0 6 1", wr_en, cursor_col, char_ready);
        end
        send_char(8'hFF);
        total++;
        if (wr_en !== 1'b0 || cursor_col !== 7'd6) begin
            bad++;
            $display("FAIL code_ff got en=%b c=%0d want 0 6", wr_en, cursor_col);
        end
    endtask

    task automatic test_form_feed;
        int cyc, nwr;
        send_char(8'h0C);
        total++;
        if (wr_en !== 1'b0 || char_ready !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL ff_entry got en=%b rdy=%b r=%0d c=%0d want 0 0 0 0", wr_en, char_ready,
                     cursor_row, cursor_col);
        end
        wait_ready(cyc, nwr);
        total++;
        if (nwr != 2100 || cyc >= 5000) begin
            bad++;
            $display("FAIL ff_sweep got writes=%0d cycles=%0d want 2100", nwr, cyc);
        end
    endtask

    task automatic test_reset_mid_clear;
        int cyc, nwr;
        send_char(8'h0A);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, char_ready, cursor_row, cursor_col} !==
            {1'b0, 12'h000, 8'h20, 1'b0, 5'd0, 7'd0}) begin
            bad++;
            $display("FAIL mid_reset got en=%b a=%h d=%h rdy=%b r=%0d c=%0d", wr_en, wr_addr, wr_data,
                     char_ready, cursor_row, cursor_col);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ready(cyc, nwr);
        total++;
        if (nwr != 2100 || cyc >= 5000 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            bad++;
            $display("FAIL mid_reset_sweep got writes=%0d cycles=%0d r=%0d c=%0d want 2100", nwr, cyc,
                     cursor_row, cursor_col);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_line_wrap;
        test_row_wrap_and_cr;
        test_backspace;
        test_form_feed;
        test_reset_mid_clear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
